// File: rtl/fpu_pkg.sv
// Shared types for the sequenced FPU front end: op codes, FSM states, status flags.
package fpu_pkg;

  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1,
    FPU_DIV = 2'd2,
    FPU_MUL = 2'd3
  } funct_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic timeout;
  } fpu_flags_t;

  function automatic int fp_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fpu_out_buf.sv
// Single-entry result register: loads on completion, holds o/flags until the consumer takes it.
module fpu_out_buf import fpu_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  fpu_flags_t   d_flags,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] o,
  output fpu_flags_t   flags
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
      flags     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      o         <= d;
      flags     <= d_flags;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fpu_seq.sv
// Handshaked FPU sequencer: one op in flight through adder / iterative divider / multiplier.
// Optional watchdog in WAIT enabled by defining FPU_TIMEOUT_EN.
module fpu_seq import fpu_pkg::*; #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int MUL_LAT  = 1,
  parameter int MIN_WAIT = 2,
  parameter int MAX_CYC  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    funct,
  input  logic [fp_w(EXP_W,MAN_W)-1:0]  a,
  input  logic [fp_w(EXP_W,MAN_W)-1:0]  b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [fp_w(EXP_W,MAN_W)-1:0]  o,
  output logic [3:0]                    flags,
  output logic                          busy
);

  localparam int W      = fp_w(EXP_W, MAN_W);
  localparam int MW     = MAN_W + 1;
  localparam int SW     = EXP_W + 3;
  localparam int LZ_W   = $clog2(MW + 4);
  localparam int CNT_W  = $clog2(MAX_CYC + MIN_WAIT + MUL_LAT + 1);
  localparam int DIV_IT = MW + 2;
  localparam int DC_W   = $clog2(DIV_IT + 1);
  localparam int ADD_ST = 1;
  localparam logic [EXP_W-1:0]     EXP_MAX = '1;
  localparam logic signed [SW-1:0] BIAS    = SW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [SW-1:0] EMAX_S  = {3'b000, EXP_MAX};
  localparam logic [W-1:0]         QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic signed [SW-1:0] sx_e(input logic [EXP_W-1:0] e);
    return $signed({3'b000, e});
  endfunction

  // Clamp a working exponent into the format: underflow flushes to signed zero, overflow to inf.
  function automatic logic [W-1:0] fp_pack(input logic s, input logic signed [SW-1:0] e,
                                           input logic [MAN_W-1:0] f);
    if (e[SW-1] || e == '0) return {s, {(W-1){1'b0}}};
    if (e >= EMAX_S)        return {s, EXP_MAX, {MAN_W{1'b0}}};
    return {s, e[EXP_W-1:0], f};
  endfunction

  function automatic fpu_flags_t fl_of(input logic [W-1:0] r);
    fpu_flags_t f;
    f.zero    = (r[W-2 -: EXP_W] == '0)      && (r[MAN_W-1:0] == '0);
    f.inf     = (r[W-2 -: EXP_W] == EXP_MAX) && (r[MAN_W-1:0] == '0);
    f.nan     = (r[W-2 -: EXP_W] == EXP_MAX) && (r[MAN_W-1:0] != '0);
    f.timeout = 1'b0;
    return f;
  endfunction

  state_e             state, state_nx;
  funct_e             funct_q;
  logic [W-1:0]       a_q, b_q;
  logic [CNT_W-1:0]   cnt;
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign in_ready     = (state == S_IDLE);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      funct_q <= FPU_ADD;
      a_q     <= '0;
      b_q     <= '0;
    end else if (state == S_IDLE && in_valid) begin
      funct_q <= funct_e'(funct);
      a_q     <= a;
      b_q     <= b;
    end
  end

  // ---------------- adder: align, add/sub, normalize (truncating) ----------------
  logic                   add_sub, add_big, add_eff_sub, add_s, add_found;
  logic [EXP_W-1:0]       add_ex, add_ey, add_d;
  logic [MW+2:0]          add_mx, add_my0, add_my;
  logic [MW+3:0]          add_sum, add_norm;
  logic [LZ_W-1:0]        add_lz;
  logic signed [SW-1:0]   add_e;
  logic [W-1:0]           add_res;

  always_comb begin
    add_sub     = (funct_q == FPU_SUB);
    add_big     = {ea, fa} >= {eb, fb};
    add_s       = add_big ? sa : (sb ^ add_sub);
    add_ex      = add_big ? ea : eb;
    add_ey      = add_big ? eb : ea;
    add_d       = add_ex - add_ey;
    add_mx      = {add_ex != '0, add_big ? fa : fb, 3'b000};
    add_my0     = {add_ey != '0, add_big ? fb : fa, 3'b000};
    add_my      = (add_d > EXP_W'(MW + 2)) ? '0 : (add_my0 >> add_d);
    add_eff_sub = sa ^ sb ^ add_sub;
    add_sum     = add_eff_sub ? ({1'b0, add_mx} - {1'b0, add_my})
                              : ({1'b0, add_mx} + {1'b0, add_my});
    add_lz      = '0;
    add_found   = 1'b0;
    for (int i = MW + 2; i >= 0; i--) begin
      if (!add_found) begin
        if (add_sum[i]) add_found = 1'b1;
        else            add_lz    = add_lz + 1'b1;
      end
    end
    if (add_sum[MW+3]) begin
      add_norm = add_sum >> 1;
      add_e    = sx_e(add_ex) + SW'(1);
    end else begin
      add_norm = add_sum << add_lz;
      add_e    = sx_e(add_ex) - SW'(add_lz);
    end
    add_res = (add_sum == '0) ? '0 : fp_pack(add_s, add_e, add_norm[MW+1:3]);
  end

  // Registered result plus a sticky fin that clears on the next start.
  logic              add_start, add_fin;
  logic [ADD_ST:0]   vld_pipe;
  logic [W-1:0]      add_q;

  assign add_start = (state == S_ISSUE) && (funct_q == FPU_ADD || funct_q == FPU_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      add_fin  <= 1'b0;
      add_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ADD_ST-1:0], add_start};
      if (add_start) add_q <= add_res;
      add_fin  <= add_start ? 1'b0 : (add_fin | vld_pipe[ADD_ST]);
    end
  end

  // ---------------- multiplier: combinational on latched operands ----------------
  logic [2*MW-1:0]      mul_p;
  logic signed [SW-1:0] mul_e;
  logic [MAN_W-1:0]     mul_f;
  logic [W-1:0]         mul_res;

  always_comb begin
    mul_p   = {{MW{1'b0}}, ea != '0, fa} * {{MW{1'b0}}, eb != '0, fb};
    mul_e   = sx_e(ea) + sx_e(eb) - BIAS + SW'(mul_p[2*MW-1]);
    mul_f   = mul_p[2*MW-1] ? mul_p[2*MW-2 -: MAN_W] : mul_p[2*MW-3 -: MAN_W];
    mul_res = (ea == '0 || eb == '0) ? {sa ^ sb, {(W-1){1'b0}}} : fp_pack(sa ^ sb, mul_e, mul_f);
  end

  // ---------------- divider: restoring, one quotient bit per cycle ----------------
  logic                 div_start, div_run, div_fin;
  logic [DC_W-1:0]      div_cnt;
  logic [MW+1:0]        div_rem, div_q, div_mb;
  logic signed [SW-1:0] div_e;
  logic [MAN_W-1:0]     div_f;
  logic [W-1:0]         div_res;

  assign div_start = (state == S_ISSUE) && (funct_q == FPU_DIV);
  assign div_mb    = {2'b00, eb != '0, fb};

  always_ff @(posedge clk) begin
    if (rst) begin
      div_run <= 1'b0;
      div_fin <= 1'b0;
      div_cnt <= '0;
      div_rem <= '0;
      div_q   <= '0;
    end else if (div_start) begin
      div_run <= 1'b1;
      div_fin <= 1'b0;
      div_cnt <= '0;
      div_rem <= {2'b00, ea != '0, fa};
      div_q   <= '0;
    end else if (div_run) begin
      if (div_rem >= div_mb) begin
        div_rem <= (div_rem - div_mb) << 1;
        div_q   <= {div_q[MW:0], 1'b1};
      end else begin
        div_rem <= div_rem << 1;
        div_q   <= {div_q[MW:0], 1'b0};
      end
      div_cnt <= div_cnt + 1'b1;
      if (div_cnt == DC_W'(DIV_IT - 1)) begin
        div_run <= 1'b0;
        div_fin <= 1'b1;
      end
    end
  end

  // Quotient lies in (0.5, 2): top bit set means it is already normalized.
  always_comb begin
    div_e = sx_e(ea) - sx_e(eb) + BIAS - SW'(!div_q[MW+1]);
    div_f = div_q[MW+1] ? div_q[MW -: MAN_W] : div_q[MW-1 -: MAN_W];
    if (eb == '0)
      div_res = (ea == '0) ? QNAN : {sa ^ sb, EXP_MAX, {MAN_W{1'b0}}};
    else if (ea == '0)
      div_res = {sa ^ sb, {(W-1){1'b0}}};
    else
      div_res = fp_pack(sa ^ sb, div_e, div_f);
  end

  // ---------------- sequencer ----------------
  logic         u_done, load;
  logic [W-1:0] u_res, ld_o;
  fpu_flags_t   ld_f, flags_s;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst)                                cnt <= '0;
    else if (state == S_ISSUE)              cnt <= '0;
    else if (state == S_WAIT && cnt != '1)  cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    u_done   = 1'b0;
    u_res    = '0;
    load     = 1'b0;
    ld_o     = '0;
    ld_f     = '0;
    unique case (funct_q)
      FPU_ADD, FPU_SUB: begin
        u_done = (cnt >= CNT_W'(MIN_WAIT)) && add_fin;
        u_res  = add_q;
      end
      FPU_DIV: begin
        u_done = (cnt >= CNT_W'(MIN_WAIT)) && div_fin;
        u_res  = div_res;
      end
      FPU_MUL: begin
        u_done = (cnt == CNT_W'(MUL_LAT - 1));
        u_res  = mul_res;
      end
    endcase
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (u_done) begin
          load     = 1'b1;
          ld_o     = u_res;
          ld_f     = fl_of(u_res);
          state_nx = S_DONE;
        end
`ifdef FPU_TIMEOUT_EN
        else if (cnt == CNT_W'(MAX_CYC - 1)) begin
          load         = 1'b1;
          ld_o         = '1;
          ld_f.timeout = 1'b1;
          state_nx     = S_DONE;
        end
`endif
      end
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  fpu_out_buf #(.W(W)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .d         (ld_o),
    .d_flags   (ld_f),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .o         (o),
    .flags     (flags_s)
  );

  assign flags = flags_s;

endmodule
